// File: rtl/fft_stream_framer.sv
// ---------------------------------------------------------------------------
// fft_stream_framer
//
// Streaming adapter between a valid/ready sample source and the FFT core's
// sink/source handshake.
//
// Input side:
//   - Frames the sample stream into N = 2^LOG2N point frames.
//   - Marks the first sample of each frame with core_sink_sop.
//   - Optionally forces GAP idle cycles between frames.
//   - Stalls while the core deasserts core_sink_ena.
// Output side:
//   - Registers core results and checks sop/eop placement.
//   - Counts frames.
//   - Optionally renormalises block-floating-point results.
//
// Build option:
//   FFT_FRAMER_EXP_NORM_EN
//     defined   : results are shifted left by -core_exp (clamped to
//                 0..OUT_W-DATA_W) and m_exp is forced to 0.
//     undefined : results are sign-extended passthrough with m_exp = core_exp.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   s_valid/s_ready/s_real/s_imag
//                               upstream sample stream
//   core_sink_ena               core ready for input
//   core_sink_dav/_sop          to core
//   core_real_in/_imag_in       to core
//   core_source_ena/_sop/_eop   result strobes from core
//   core_real_out/_imag_out     result data from core
//   core_exp                    block exponent from core
//   core_source_dav             downstream ready forwarded to core
//   m_ready                     downstream ready
//   m_valid/m_sop/m_eop         result stream
//   m_real/m_imag               result components (OUT_W)
//   m_exp                       exponent as delivered
//   frames_in, frames_out       completed frame counters (wrap at 2^16)
//   err_frame, err_exp          sticky error flags
// ---------------------------------------------------------------------------
module fft_stream_framer #(
   parameter int DATA_W = 16,
   parameter int LOG2N  = 10,
   parameter int EXP_W  = 6,
   parameter int GAP    = 0,
   parameter int OUT_W  = DATA_W + LOG2N + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_real,
   input  logic [DATA_W-1:0] s_imag,
   input  logic              core_sink_ena,
   output logic              core_sink_dav,
   output logic              core_sink_sop,
   output logic [DATA_W-1:0] core_real_in,
   output logic [DATA_W-1:0] core_imag_in,
   input  logic              core_source_ena,
   input  logic              core_source_sop,
   input  logic              core_source_eop,
   input  logic [DATA_W-1:0] core_real_out,
   input  logic [DATA_W-1:0] core_imag_out,
   input  logic [EXP_W-1:0]  core_exp,
   output logic              core_source_dav,
   input  logic              m_ready,
   output logic              m_valid,
   output logic              m_sop,
   output logic              m_eop,
   output logic [OUT_W-1:0]  m_real,
   output logic [OUT_W-1:0]  m_imag,
   output logic [EXP_W-1:0]  m_exp,
   output logic [15:0]       frames_in,
   output logic [15:0]       frames_out,
   output logic              err_frame,
   output logic              err_exp
);

   localparam logic [LOG2N-1:0] LAST     = LOG2N'((1 << LOG2N) - 1);
   localparam logic [7:0]       GAP_LAST = 8'(GAP - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_GAP} state_t;

   // ------------------------------------------------------------------
   // Input framing
   // ------------------------------------------------------------------
   state_t              state_q;
   logic [LOG2N-1:0]    idx_q;
   logic [7:0]          gap_cnt_q;
   logic                ena_q;
   logic                dav_q;
   logic                sop_q;
   logic [DATA_W-1:0]   re_in_q;
   logic [DATA_W-1:0]   im_in_q;
   logic [15:0]         frames_in_q;
   logic                xfer;

   assign s_ready = ena_q & (state_q != ST_GAP);
   assign xfer    = s_valid & s_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         gap_cnt_q   <= '0;
         ena_q       <= 1'b0;
         dav_q       <= 1'b0;
         sop_q       <= 1'b0;
         re_in_q     <= '0;
         im_in_q     <= '0;
         frames_in_q <= '0;
      end else begin
         ena_q <= core_sink_ena;
         dav_q <= 1'b1;
         // sop is a one-cycle strobe; data holds when nothing is accepted
         sop_q <= xfer && (idx_q == '0);
         if (xfer) begin
            re_in_q <= s_real;
            im_in_q <= s_imag;
         end
         case (state_q)
            ST_IDLE, ST_FILL: begin
               if (xfer) begin
                  state_q <= ST_FILL;
                  if (idx_q == LAST) begin
                     idx_q       <= '0;
                     frames_in_q <= frames_in_q + 16'd1;
                     if (GAP > 0) begin
                        state_q   <= ST_GAP;
                        gap_cnt_q <= '0;
                     end
                  end else begin
                     idx_q <= idx_q + LOG2N'(1);
                  end
               end
            end
            ST_GAP: begin
               // s_ready is low for exactly GAP cycles after the last sample
               if (gap_cnt_q == GAP_LAST) state_q   <= ST_FILL;
               else                       gap_cnt_q <= gap_cnt_q + 8'd1;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign core_sink_dav = dav_q;
   assign core_sink_sop = sop_q;
   assign core_real_in  = re_in_q;
   assign core_imag_in  = im_in_q;

   // ------------------------------------------------------------------
   // Result formatting
   // ------------------------------------------------------------------
   logic [OUT_W-1:0] re_ext, im_ext;
   logic [OUT_W-1:0] re_d, im_d;
   logic [EXP_W-1:0] exp_d;
   logic             exp_bad_d;

   assign re_ext = {{(OUT_W-DATA_W){core_real_out[DATA_W-1]}}, core_real_out};
   assign im_ext = {{(OUT_W-DATA_W){core_imag_out[DATA_W-1]}}, core_imag_out};

`ifdef FFT_FRAMER_EXP_NORM_EN
   localparam int LIM = OUT_W - DATA_W;

   // one extra bit so that negating the most negative exponent cannot overflow
   logic signed [EXP_W:0] neg_exp;
   logic        [EXP_W:0] sh_d;

   assign neg_exp = -$signed({core_exp[EXP_W-1], core_exp});

   always_comb begin
      sh_d      = neg_exp;
      exp_bad_d = 1'b0;
      if (neg_exp < 0) begin
         sh_d      = '0;
         exp_bad_d = 1'b1;
      end else if (int'(neg_exp) > LIM) begin
         sh_d      = (EXP_W+1)'(LIM);
         exp_bad_d = 1'b1;
      end
   end

   assign re_d  = re_ext << sh_d;
   assign im_d  = im_ext << sh_d;
   assign exp_d = '0;
`else
   assign re_d      = re_ext;
   assign im_d      = im_ext;
   assign exp_d     = core_exp;
   assign exp_bad_d = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Result register and frame integrity check
   // ------------------------------------------------------------------
   logic [LOG2N-1:0] oidx_q, oidx_eff;
   logic             m_valid_q, m_sop_q, m_eop_q;
   logic [OUT_W-1:0] m_re_q, m_im_q;
   logic [EXP_W-1:0] m_exp_q;
   logic [15:0]      frames_out_q;
   logic             err_frame_q, err_exp_q;

   // a sop always marks sample 0, so it resynchronises the index
   assign oidx_eff = core_source_sop ? '0 : oidx_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         oidx_q       <= '0;
         m_valid_q    <= 1'b0;
         m_sop_q      <= 1'b0;
         m_eop_q      <= 1'b0;
         m_re_q       <= '0;
         m_im_q       <= '0;
         m_exp_q      <= '0;
         frames_out_q <= '0;
         err_frame_q  <= 1'b0;
         err_exp_q    <= 1'b0;
      end else begin
         m_valid_q <= core_source_ena;
         m_sop_q   <= core_source_ena & core_source_sop;
         m_eop_q   <= core_source_ena & core_source_eop;
         if (core_source_ena) begin
            m_re_q  <= re_d;
            m_im_q  <= im_d;
            m_exp_q <= exp_d;
            if (core_source_sop && (oidx_q != '0))   err_frame_q <= 1'b1;
            if (core_source_eop && (oidx_eff != LAST)) err_frame_q <= 1'b1;
            if (core_source_eop && (oidx_eff == LAST)) begin
               oidx_q       <= '0;
               frames_out_q <= frames_out_q + 16'd1;
            end else begin
               oidx_q <= oidx_eff + LOG2N'(1);
            end
            if (exp_bad_d) err_exp_q <= 1'b1;
         end
      end
   end

   assign core_source_dav = m_ready;
   assign m_valid    = m_valid_q;
   assign m_sop      = m_sop_q;
   assign m_eop      = m_eop_q;
   assign m_real     = m_re_q;
   assign m_imag     = m_im_q;
   assign m_exp      = m_exp_q;
   assign frames_in  = frames_in_q;
   assign frames_out = frames_out_q;
   assign err_frame  = err_frame_q;
   assign err_exp    = err_exp_q;

endmodule

// File: doc/fft_stream_framer.md
# fft_stream_framer

Parametrised streaming adapter between a valid/ready sample source and the FFT MegaCore's sink/source handshake (sink_dav/sink_ena/sink_sop, source_dav/source_ena/source_sop/source_eop). It generates sample-exact frame framing for an N = 2^LOG2N point transform, with optional inter-frame gaps and backpressure from the core. It checks output frame integrity and optionally renormalises block-floating-point results to a common fixed-point scale. It sits between the acquisition datapath and the FFT core in the processing chain.

## Interface
- DATA_W, 16, sample/result component width (two's complement)
- LOG2N, 10, log2 of frame length N
- EXP_W, 6, block exponent width (signed)
- GAP, 0, idle cycles forced between input frames (0..255)
- OUT_W, DATA_W+LOG2N+1, output component width
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- s_valid  in  1  upstream sample valid
- s_ready  out  1  upstream sample accepted when s_valid&s_ready
- s_real, s_imag  in  DATA_W  upstream sample
- core_sink_ena  in  1  core ready to accept input
- core_sink_dav, core_sink_sop  out  1  to core
- core_real_in, core_imag_in  out  DATA_W  to core
- core_source_ena, core_source_sop, core_source_eop  in  1  from core
- core_real_out, core_imag_out  in  DATA_W  from core
- core_exp  in  EXP_W  block exponent from core
- core_source_dav  out  1  downstream ready to core (= m_ready)
- m_ready  in  1  downstream ready
- m_valid, m_sop, m_eop  out  1  result stream
- m_real, m_imag  out  OUT_W  result components
- m_exp  out  EXP_W  exponent as delivered
- frames_in, frames_out  out  16  completed frame counters, wrap at 2^16
- err_frame, err_exp  out  1  sticky error flags, cleared only by reset

## Operation
- Reset: all outputs 0; FSM in IDLE; sample index 0; ena_q 0.
- ena_q = core_sink_ena registered; core_sink_dav = 1 from first cycle after reset deasserts.
- s_ready = ena_q & (state != GAP); transfer = s_valid & s_ready.
- FSM: IDLE -> FILL on first transfer. FILL: index increments on each transfer. On the transfer at index N-1, index wraps to 0, frames_in increments, and the FSM moves to GAP if GAP>0; otherwise it stays in FILL. GAP: counts GAP cycles, then returns to FILL.
- On each transfer, s_real and s_imag are registered to core_real_in and core_imag_in, and core_sink_sop is set to (index==0) for one cycle. When there is no transfer, core_sink_sop is 0 and the data outputs hold their values.
- ena_q falling mid-frame stalls the index; the frame resumes with no sop reissued.
- Output: on core_source_ena, register the result. m_valid=1 next cycle, otherwise 0. m_sop and m_eop copy core_source_sop and core_source_eop.
- Output check, using an output index of LOG2N bits:
  - core_source_sop with index≠0 sets err_frame and resyncs the index to 1.
  - core_source_eop with index≠N-1 sets err_frame.
  - A valid eop increments frames_out and resets the index to 0.
- Without normalisation: m_real and m_imag are the sign-extended core outputs; m_exp = core_exp.

## Timing
- Input latency: transfer at edge t -> core_real_in/core_sink_sop valid after edge t+1.
- Output latency: core_source_ena at edge t -> m_valid after edge t+1 (normalisation is combinational before the register).
- Frame period with continuous input and ena_q=1: N+GAP cycles; sop spacing exactly N+GAP.
- Simultaneous last-sample transfer and GAP entry: the last sample is accepted, and s_ready drops the following cycle.
- Synchronous reset mid-frame: the partial frame is discarded; the next accepted sample carries sop.

## Configuration
- FFT_FRAMER_EXP_NORM_EN defined:
  - The shift amount is -core_exp. Results are sign-extended and shifted left by this amount, so m_real = core_real_out·2^(-core_exp).
  - m_exp is forced to 0.
  - core_exp > 0 or -core_exp > OUT_W-DATA_W: the shift is clamped to the limit (0 or OUT_W-DATA_W) and err_exp is set.
- Undefined: raw passthrough as described in Operation; err_exp stays 0.

## Test plan
- Reset 5 cycles, all ports driven: every output reads 0; core_sink_dav=1 one cycle after reset deasserts.
- LOG2N=4, GAP=0, continuous s_valid, core_sink_ena=1: sop every 16 cycles; frames_in=3 after 48 transfers; data order preserved.
- Same bench with core_sink_ena low for 5 cycles at index 7: s_ready=0 for those cycles; index resumes at 7; no extra sop; sop spacing 21.
- GAP=2: s_ready low exactly 2 cycles after each 16th transfer; sop spacing 18.
- Normalisation enabled, core_real_out=16'h0101, core_exp=-3: m_real=0x0808 sign-extended. core_real_out=16'hFFFF, exp=-1: m_real=-2. core_exp=-20 with OUT_W=21: shift clamped to 5 and err_exp=1.
- core_source_sop at output index 9: err_frame=1, output index resyncs to 1. A proper eop 15 results later increments frames_out by 1.
